// File: rtl/qsram_pkg.sv
// qsram_pkg: shared QSRAM widths, controller FSM states and pin command encodings
package qsram_pkg;
  localparam int QSRAM_ADDR_WIDTH = 30;
  localparam int QSRAM_DATA_WIDTH = 9;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_CMD,
    READ_WAIT,
    READ_CAPTURE,
    TURNAROUND,
    REFRESH
  } state_t;
  // {enable, read, write, refresh}
  localparam logic [3:0] CMD_NOP     = 4'b0000;
  localparam logic [3:0] CMD_READ    = 4'b1100;
  localparam logic [3:0] CMD_WRITE   = 4'b1010;
  localparam logic [3:0] CMD_REFRESH = 4'b1001;
endpackage

// File: rtl/qsram_refresh_timer.sv
// qsram_refresh_timer: free-running refresh interval counter with a sticky pending flag
module qsram_refresh_timer #(
  parameter int INTERVAL = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic pending
);
  localparam int CW = $clog2(INTERVAL);
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = cnt == '0;
  // a tick wins over a same-cycle clear so no refresh request is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= CW'(INTERVAL - 1);
      pending <= 1'b0;
    end else begin
      cnt <= tick ? CW'(INTERVAL - 1) : cnt - 1'b1;
      pending <= tick | (pending & ~clr);
    end
endmodule

// File: rtl/qsram_controller.sv
// qsram_controller: host request/response to SDR QSRAM pins with auto-refresh and read latency handling
module qsram_controller
  import qsram_pkg::*;
#(
  parameter int ADDR_WIDTH       = QSRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH       = QSRAM_DATA_WIDTH,
  parameter int READ_LATENCY     = 2,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  enable,
  output logic                  read,
  output logic                  write,
  output logic                  refresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_enable,
  input  logic [DATA_WIDTH-1:0] data_in
);
  localparam int WW = $clog2(READ_LATENCY + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("qsram_controller: READ_LATENCY must be at least 1");
  end
  if (REFRESH_INTERVAL <= REFRESH_CYCLES + READ_LATENCY + 4) begin : g_bad_interval
    $error("qsram_controller: REFRESH_INTERVAL too short to keep refresh ticks from overlapping");
  end

  state_t        state;
  logic [3:0]    cmd;
  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] ref_cnt;
  logic          pending;
  logic          clr;

  assign {enable, read, write, refresh} = cmd;
  assign clr = state == IDLE && pending;
  assign req_ready = rst_n && state == IDLE && !pending;

  qsram_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .pending(pending)
  );

  // command pins and the response strobe default low; each state re-asserts what it needs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd <= CMD_NOP;
      address <= '0;
      data_out <= '0;
      data_out_enable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      wait_cnt <= '0;
      ref_cnt <= '0;
    end else begin
      cmd <= CMD_NOP;
      rsp_valid <= 1'b0;
      data_out_enable <= 1'b0;
      case (state)
        IDLE:
          if (pending) begin
            state <= REFRESH;
            cmd <= CMD_REFRESH;
            address <= '0;
            ref_cnt <= RW'(REFRESH_CYCLES - 1);
          end else if (req_valid) begin
            address <= req_addr;
            if (req_write) begin
              state <= WRITE;
              cmd <= CMD_WRITE;
              data_out <= req_data;
              data_out_enable <= 1'b1;
            end else begin
              state <= READ_CMD;
              cmd <= CMD_READ;
            end
          end
        WRITE: state <= IDLE;
        READ_CMD: begin
          state <= (READ_LATENCY > 1) ? READ_WAIT : READ_CAPTURE;
          wait_cnt <= WW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
        end
        READ_WAIT:
          if (wait_cnt == '0) state <= READ_CAPTURE;
          else wait_cnt <= wait_cnt - 1'b1;
        READ_CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_data <= data_in;
          state <= TURNAROUND;
        end
        TURNAROUND: state <= IDLE;
        REFRESH:
          if (ref_cnt == '0) state <= IDLE;
          else begin
            ref_cnt <= ref_cnt - 1'b1;
            cmd <= CMD_REFRESH;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qsram_controller.sv
// tb_qsram_controller: directed and random host traffic against a QSRAM device model and host-level memory reference
module tb_qsram_controller;
  localparam int AW = 30;
  localparam int DW = 9;
  localparam int RL = 2;
  localparam int RI = 16;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic req_ready, rsp_valid, enable, read, write, refresh, data_out_enable;
  logic [DW-1:0] rsp_data, data_out, data_in;
  logic [AW-1:0] address;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rsp_cyc = 0;
  int wr_cyc = 0;
  int rd_cyc = 0;
  int t0;

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] dpipe [RL];
  logic vpipe [RL];
  logic [DW-1:0] junk = '0;

  qsram_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
    .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .address(address),
    .enable(enable), .read(read), .write(write), .refresh(refresh),
    .data_out(data_out), .data_out_enable(data_out_enable), .data_in(data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 9'h0C3;
  endfunction

  // QSRAM device: stores on Write, drives read data in the cycle READ_LATENCY after Read, junk otherwise
  always @(posedge clk) begin
    if (enable && write) dev_mem[address] = data_out;
    vpipe[0] <= enable && read;
    dpipe[0] <= dev_mem.exists(address) ? dev_mem[address] : dflt(address);
    for (int i = 1; i < RL; i++) begin
      vpipe[i] <= vpipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
    junk <= DW'($urandom);
  end
  assign data_in = vpipe[RL-1] ? dpipe[RL-1] : junk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (refresh) chk("refresh_pins", {enable, read, write, data_out_enable, address}, {4'b1000, 30'd0});
      if (read) chk("read_cmd_doe", data_out_enable, 0);
    end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic wait_window();
    int n = 0;
    while (!refresh && n < 2 * RI) begin
      @(negedge clk);
      n++;
    end
    chk("refresh_seen", refresh, 1);
    n = 0;
    while (refresh && n < 2 * RI) begin
      @(negedge clk);
      n++;
    end
    chk("refresh_end", refresh, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = a;
    req_data = d;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    wr_cyc = cyc;
    chk("wr_pins", {enable, read, write, refresh, data_out_enable}, 5'b10101);
    chk("wr_addr", address, a);
    chk("wr_data", data_out, d);
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_end", {enable, write, data_out_enable}, 3'b000);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    exp = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = a;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    rd_cyc = cyc;
    chk("rd_pins", {enable, read, write, refresh, data_out_enable}, 5'b11000);
    chk("rd_addr", address, a);
    for (int i = 1; i <= RL + 2; i++) begin
      @(negedge clk);
      chk("rd_doe", data_out_enable, 0);
      chk("rd_valid", rsp_valid, i == RL + 1);
      if (i == RL + 1) begin
        chk("rd_data", rsp_data, exp);
        rsp_cyc = cyc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {req_ready, rsp_valid, rsp_data, address, enable, read, write, refresh,
                       data_out, data_out_enable}, 0);
    rst_n = 1'b1;
    // idle: refresh bursts of RC cycles every RI cycles, ready low while pending or refreshing
    repeat (2 * RI + RC + 2) begin
      @(negedge clk);
      chk("idle_refresh", refresh, cyc > RI && cyc % RI >= 1 && cyc % RI <= RC);
      chk("idle_ready", req_ready, !(cyc >= RI && cyc % RI <= RC));
    end
    wait_window();
    do_write(30'h1234, 9'h1A5);
    chk("wr_ready_k2", req_ready, 1);
    wait_window();
    do_write(30'h10, 9'h0F3);
    do_read(30'h10);
    wait_window();
    do_read(30'h20);
    do_write(30'h21, 9'h055);
    chk("turnaround_gap", wr_cyc - rsp_cyc, 2);
    // pending refresh beats a request that is already waiting
    for (int n = 0; n < RI && cyc % RI != 0; n++) @(negedge clk);
    chk("coll_ready", req_ready, 0);
    t0 = cyc;
    do_read(30'h1234);
    chk("coll_cmd_cycle", rd_cyc - t0, RC + 2);
    // acceptance on the tick edge: the read finishes, then refresh follows
    for (int n = 0; n < RI && cyc % RI != RI - 1; n++) @(negedge clk);
    do_read(30'h21);
    chk("tick_cmd_cycle", rd_cyc % RI, 0);
    chk("tick_ready", req_ready, 0);
    @(negedge clk);
    chk("tick_refresh_after", refresh, 1);
    // reset while waiting on read data
    wait_window();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 30'h55;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {req_ready, rsp_valid, rsp_data, address, enable, read, write, refresh,
                         data_out, data_out_enable}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RI + 2) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
      chk("rst_refresh", refresh, cyc > RI);
      chk("rst_ready", req_ready, cyc < RI);
    end
    do_read(30'h10);
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a;
      a = 30'h100 + AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
      else do_read(a);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
